// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the seven-segment display reader:
//   - state_t      : frame-assembly state encoding (IDLE / COLLECT / FULL)
//   - COUNT_W      : width of the digit counter (enough for up to 8 digits)
//   - SEG_HEX_0..F : active-low segment patterns (g,f,e,d,c,b,a) for hex 0..F
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam int COUNT_W = 4;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/display_reader_seg_to_hex.sv
// -----------------------------------------------------------------------------
// seg_to_hex
// Combinational decode of an active-low seven-segment pattern into a hex
// nibble. Any pattern not in the 16-entry table is reported as invalid.
// Ports:
//   seg    in  [6:0] segment pattern g,f,e,d,c,b,a (active-low, dp excluded)
//   nibble out [3:0] decoded hex value (0 when invalid)
//   valid  out       1 when seg matches a table entry
// -----------------------------------------------------------------------------
module seg_to_hex
    import display_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       valid
);

    // Table lookup; unmatched patterns fall to default and flag invalid.
    always_comb begin
        nibble = 4'h0;
        valid  = 1'b1;
        case (seg)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/display_reader.sv
// -----------------------------------------------------------------------------
// display_reader
// Recovers hex frames from a stream of active-low seven-segment patterns.
// Digits are accepted on in_valid & in_ready, decoded, and shifted into an
// assembly register; once DIGITS digits are collected the frame is presented
// on word_out/out_valid and held until out_ready. Invalid patterns set the
// sticky err flag and discard the partial frame.
//
// Optional feature (macro DP_FRAME_EN): an accepted valid digit with the
// decimal point lit (seg_in[7]=0) restarts the frame with itself as MS nibble.
// Without the macro, seg_in[7] has no effect.
//
// Parameters:
//   DIGITS     digits per frame (1..8)
// Ports:
//   clk        in            clock, rising edge
//   rst        in            asynchronous active-high reset
//   seg_in     in  [7:0]     segment pattern, active-low (bit 7 = dp)
//   in_valid   in            seg_in offered
//   in_ready   out           digit accepted this cycle when in_valid=1
//   word_out   out [4*DIGITS-1:0] last complete frame, first digit in MS nibble
//   out_valid  out           word_out holds an unconsumed frame
//   out_ready  in            consumer takes word_out
//   err        out           sticky invalid-pattern flag
//   err_clr    in            synchronous clear of err (a new error wins)
// -----------------------------------------------------------------------------
module display_reader
    import display_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   word_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err,
    input  logic                  err_clr
);

    localparam int                 WORD_W     = 4 * DIGITS;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(DIGITS);

    state_t               state_r;
    state_t               state_next_s;
    logic [COUNT_W-1:0]   count_r;
    logic [COUNT_W-1:0]   count_next_s;
    logic [COUNT_W-1:0]   base_count_s;
    logic [COUNT_W-1:0]   inc_count_s;
    logic [WORD_W-1:0]    asm_r;
    logic [WORD_W-1:0]    asm_next_s;
    logic [WORD_W-1:0]    base_asm_s;
    logic [WORD_W-1:0]    shifted_s;
    logic [WORD_W-1:0]    word_r;
    logic                 out_valid_r;
    logic                 in_ready_r;
    logic                 err_r;
    logic [3:0]           hex_nibble_s;
    logic                 hex_valid_s;
    logic                 accept_s;
    logic                 frame_start_s;
    logic                 load_word_s;
    logic                 set_err_s;

    seg_to_hex u_seg_to_hex (
        .seg    (seg_in[6:0]),
        .nibble (hex_nibble_s),
        .valid  (hex_valid_s)
    );

    assign accept_s = in_valid & in_ready_r;

`ifdef DP_FRAME_EN
    // A lit decimal point (active-low) marks the first digit of a frame.
    assign frame_start_s = ~seg_in[7];
`else
    // The decimal point is referenced but has no effect in this build.
    assign frame_start_s = 1'b0 & seg_in[7];
`endif

    // Candidate assembly value: restart on frame start, then shift in the nibble.
    always_comb begin
        if (frame_start_s) begin
            base_count_s = {COUNT_W{1'b0}};
            base_asm_s   = {WORD_W{1'b0}};
        end else begin
            base_count_s = count_r;
            base_asm_s   = asm_r;
        end
        inc_count_s    = base_count_s + {{(COUNT_W-1){1'b0}}, 1'b1};
        // Shift form keeps DIGITS=1 legal (the old contents fall off entirely).
        shifted_s      = base_asm_s << 4;
        shifted_s[3:0] = hex_nibble_s;
    end

    // Next-state, counter and assembly-register logic.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        asm_next_s   = asm_r;
        load_word_s  = 1'b0;
        set_err_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if (accept_s) begin
                    if (!hex_valid_s) begin
                        set_err_s    = 1'b1;
                        state_next_s = ST_IDLE;
                        count_next_s = {COUNT_W{1'b0}};
                        asm_next_s   = {WORD_W{1'b0}};
                    end else if (inc_count_s == LAST_COUNT) begin
                        // Last digit: publish the frame and clear assembly.
                        load_word_s  = 1'b1;
                        state_next_s = ST_FULL;
                        count_next_s = {COUNT_W{1'b0}};
                        asm_next_s   = {WORD_W{1'b0}};
                    end else begin
                        state_next_s = ST_COLLECT;
                        count_next_s = inc_count_s;
                        asm_next_s   = shifted_s;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean empty state.
                state_next_s = ST_IDLE;
                count_next_s = {COUNT_W{1'b0}};
                asm_next_s   = {WORD_W{1'b0}};
            end
        endcase
    end

    // State, counter and assembly registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            count_r <= {COUNT_W{1'b0}};
            asm_r   <= {WORD_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            asm_r   <= asm_next_s;
        end
    end

    // Handshake flags registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            out_valid_r <= (state_next_s == ST_FULL);
            in_ready_r  <= (state_next_s != ST_FULL);
        end
    end

    // Output frame register; retains the last frame outside FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r <= {WORD_W{1'b0}};
        end else if (load_word_s) begin
            word_r <= shifted_s;
        end else begin
            word_r <= word_r;
        end
    end

    // Sticky error flag; a new error outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (set_err_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign word_out  = word_r;
    assign err       = err_r;

endmodule

// File: tb/tb_display_reader.sv
// -----------------------------------------------------------------------------
// tb_display_reader
// Directed self-checking bench for display_reader (DIGITS = 4).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at that same point, well clear of the next active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_display_reader;

    logic        clk;
    logic        rst;
    logic [7:0]  seg_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] word_out;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic        err_clr;

    int tests_run;
    int tests_failed;

    display_reader #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .word_out  (word_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer n patterns back-to-back; seq holds them MS byte first.
    task automatic send_seq(input logic [47:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            seg_in   = seq[8*(n-1-i) +: 8];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        seg_in   = 8'hFF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (word_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_word: got %h expected 0000", word_out); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_seq(48'h0000_7924_3019, 4);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_out_valid: got %b expected 1", out_valid); end
        tests_run++;
        if (word_out !== 16'h1234) begin tests_failed++; $display("FAIL b2b_word: got %h expected 1234", word_out); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_in_ready_full: got %b expected 0", in_ready); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_out_valid_drop: got %b expected 0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready_idle: got %b expected 1", in_ready); end
        tests_run++;
        if (word_out !== 16'h1234) begin tests_failed++; $display("FAIL b2b_word_retained: got %h expected 1234", word_out); end
    endtask

    task automatic test_hold();
        int bad;
        out_ready = 1'b0;
        send_seq(48'h0000_0803_4621, 4);
        bad = 0;
        // Keep offering a digit while full; it must not be taken.
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || word_out !== 16'hABCD) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: got in_ready=%b out_valid=%b word=%h expected 0 1 abcd",
                         i, in_ready, out_valid, word_out);
            end
            seg_in   = 8'h40;
            in_valid = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_release_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (word_out !== 16'hABCD) begin tests_failed++; $display("FAIL hold_release_word: got %h expected abcd", word_out); end
    endtask

    task automatic test_reset_mid();
        send_seq(48'h0000_0000_7924, 2);
        rst = 1'b1;
        #2;
        tests_run++;
        if (word_out !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_word: got %h expected 0000", word_out); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        tick();
        send_seq(48'h0000_0010_7802, 4);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_out_valid: got %b expected 1", out_valid); end
        tests_run++;
        if (word_out !== 16'h8976) begin tests_failed++; $display("FAIL rstmid_frame: got %h expected 8976", word_out); end
        tick();
    endtask

    task automatic test_invalid();
        out_ready = 1'b1;
        send_seq(48'h0000_0000_407F, 2);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL inv_err_set: got %b expected 1", err); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL inv_in_ready: got %b expected 1", in_ready); end
        send_seq(48'h0000_0040_4040, 3);
        // The pre-error digit must be gone, so three digits are not a frame.
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL inv_partial_dropped: got %b expected 0", out_valid); end
        send_seq(48'h0000_0000_0040, 1);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL inv_out_valid: got %b expected 1", out_valid); end
        tests_run++;
        if (word_out !== 16'h0000) begin tests_failed++; $display("FAIL inv_word: got %h expected 0000", word_out); end
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL inv_err_sticky: got %b expected 1", err); end
        tick();
    endtask

    task automatic test_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL errclr_first: got %b expected 0", err); end
        err_clr  = 1'b1;
        seg_in   = 8'h7F;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL errclr_collision: got %b expected 1", err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL errclr_alone: got %b expected 0", err); end
    endtask

    task automatic test_pause();
        out_ready = 1'b1;
        send_seq(48'h0000_0000_0079, 1);
        repeat (5) tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL pause_no_frame: got %b expected 0", out_valid); end
        send_seq(48'h0000_0000_0024, 1);
        repeat (3) tick();
        send_seq(48'h0000_0000_3019, 2);
        tests_run++;
        if (word_out !== 16'h1234) begin tests_failed++; $display("FAIL pause_word: got %h expected 1234", word_out); end
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL pause_out_valid: got %b expected 1", out_valid); end
        tick();
    endtask

`ifdef DP_FRAME_EN
    task automatic test_dp_frame();
        out_ready = 1'b1;
        send_seq(48'hF9A4_40B0_9992, 6);
        tests_run++;
        if (word_out !== 16'h0345) begin tests_failed++; $display("FAIL dp_frame_word: got %h expected 0345", word_out); end
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL dp_frame_valid: got %b expected 1", out_valid); end
        tick();
    endtask
`else
    task automatic test_dp_ignored();
        out_ready = 1'b1;
        send_seq(48'h0000_F9A4_40B0, 4);
        tests_run++;
        if (word_out !== 16'h1203) begin tests_failed++; $display("FAIL dp_ignored_word: got %h expected 1203", word_out); end
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL dp_ignored_valid: got %b expected 1", out_valid); end
        tick();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        seg_in       = 8'hFF;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        err_clr      = 1'b0;
        #1;
        test_reset();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_invalid();
        test_err_clr();
        test_pause();
`ifdef DP_FRAME_EN
        test_dp_frame();
`else
        test_dp_ignored();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/display_reader.md
DISPLAY_READER -- requirements
Module: display_reader

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of digits per frame (legal 1..8).
REQ-002 SHALL have port clk input 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-004 SHALL have port seg_in input 8: segment pattern, active-low; bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a.
REQ-005 SHALL have port in_valid input 1: seg_in is offered this cycle.
REQ-006 SHALL have port in_ready output 1: block accepts seg_in this cycle.
REQ-007 SHALL have port word_out output 4*DIGITS: recovered hex frame, first-received digit in the MS nibble.
REQ-008 SHALL have port out_valid output 1: word_out holds a complete frame.
REQ-009 SHALL have port out_ready input 1: consumer takes word_out this cycle.
REQ-010 SHALL have port err output 1: sticky flag for an invalid pattern seen.
REQ-011 SHALL have port err_clr input 1: synchronous clear of err.

Function
REQ-012 SHALL transfer a digit only on a cycle with in_valid=1 and in_ready=1.
REQ-013 SHALL map seg_in[6:0] to a nibble, ignoring dp, per table: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex, active-low).
REQ-014 SHALL treat any other seg_in[6:0] as invalid: set err, discard the partial frame, return to IDLE.
REQ-015 SHALL use states IDLE (count=0), COLLECT (0<count<DIGITS), FULL (frame held).
REQ-016 SHALL, on a valid accepted digit, shift the nibble into an assembly register and increment count.
REQ-017 SHALL, on acceptance of digit DIGITS, load word_out and assert out_valid the next cycle (latency 1 clk from last accept).
REQ-018 SHALL hold in_ready=0 in FULL; in_ready=1 in IDLE and COLLECT.
REQ-019 SHALL hold word_out and out_valid stable in FULL until out_ready=1, then deassert out_valid next cycle and go to IDLE.
REQ-020 SHALL leave word_out unchanged outside FULL (last frame retained).
REQ-021 SHALL give err_clr priority below a same-cycle new error (err stays 1).
REQ-022 SHALL let in_valid=0 mid-frame pause collection indefinitely without loss.

Reset
REQ-023 SHALL on rst force state IDLE, count 0, assembly register 0, word_out 0, out_valid 0, err 0; in_ready=1 after release.
REQ-024 SHALL discard a partial or held frame when rst asserts mid-operation.

Configuration
REQ-025 SHALL, with DP_FRAME_EN defined, treat an accepted valid digit with dp lit (seg_in[7]=0) as frame start: count restarts, that digit becomes the MS nibble.
REQ-026 SHALL, without DP_FRAME_EN, ignore seg_in[7] entirely.

Structure
REQ-027 SHALL place the state enumeration and the 16-entry segment table constants in shared package display_pkg.
REQ-028 SHALL implement the pattern lookup as combinational sub-module seg_to_hex (seg[6:0] in; nibble and valid out).

Verification
REQ-029 SHALL test: after rst, send 79,24,30,19 back-to-back, out_ready=1 -> word_out=16'h1234, out_valid one cycle.
REQ-030 SHALL test: frame 08,03,46,21 with out_ready=0 for 10 cycles -> in_ready=0, word_out=16'hABCD held stable throughout.
REQ-031 SHALL test: 40,7F,40,40,40,40 -> err=1 after 7F, first 40 dropped, output 16'h0000 from last four.
REQ-032 SHALL test: err_clr and invalid pattern same cycle -> err stays 1; err_clr alone next cycle -> err=0.
REQ-033 SHALL test: rst pulse after two digits, then 00,10,78,02 -> word_out=16'h8976.
REQ-034 SHALL test, DP_FRAME_EN defined: F9,A4,40,B0,99,92 (dp on 40) -> word_out=16'h0345.
